// File: rtl/fetch_decouple_queue.sv
// rtl/fetch_decouple_queue.sv - multi-lane fetch-to-issue decoupling queue
module fetch_decouple_queue #(
  parameter int                    DEPTH        = 16,
  parameter int                    PUSH_WIDTH   = 2,
  parameter int                    POP_WIDTH    = 2,
  parameter int                    LINE_WIDTH   = 128,
  parameter int                    AFULL_THRESH = DEPTH - 4,
  parameter logic [LINE_WIDTH-1:0] NOP_VALUE    = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [PUSH_WIDTH-1:0]            push_valid,
  input  logic [PUSH_WIDTH*LINE_WIDTH-1:0] push_data,
  output logic                             push_ready,
  input  logic [$clog2(POP_WIDTH+1)-1:0]   pop_count,
  output logic [POP_WIDTH-1:0]             head_valid,
  output logic [POP_WIDTH*LINE_WIDTH-1:0]  head_data,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             almost_full,
  output logic                             full,
  output logic                             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Storage carries no reset: pointers and count alone define what is valid
  logic [LINE_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic [CW-1:0]         w_off  [PUSH_WIDTH];
  logic [AW-1:0]         w_widx [PUSH_WIDTH];
  logic [CW-1:0]         w_push_num;
  logic                  w_push_fire;
  logic [CW-1:0]         w_avail;
  logic [CW-1:0]         w_pop_req;
  logic [CW-1:0]         w_pop_num;

  // Compaction: each valid lane lands after all lower valid lanes
  always_comb begin
    w_push_num = '0;
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      w_off[i]   = w_push_num;
      w_widx[i]  = AW'(r_wptr + PW'(w_push_num));
      w_push_num = w_push_num + CW'(push_valid[i]);
    end
  end

  // Space check uses pre-pop occupancy; pop is clipped to what the head shows
  always_comb begin
    push_ready  = (r_count <= CW'(DEPTH - PUSH_WIDTH));
    w_push_fire = push_ready && (push_valid != '0);
    w_avail     = (r_count > CW'(POP_WIDTH)) ? CW'(POP_WIDTH) : r_count;
    w_pop_req   = CW'(pop_count);
    w_pop_num   = (w_pop_req > w_avail) ? w_avail : w_pop_req;
  end

  // Write accepted lanes into consecutive slots from wptr
  always_ff @(posedge clk) begin
    if (w_push_fire && !flush) begin
      for (int i = 0; i < PUSH_WIDTH; i++) begin
        if (push_valid[i]) begin
          r_mem[w_widx[i]] <= push_data[i*LINE_WIDTH +: LINE_WIDTH];
        end
      end
    end
  end

  // Pointer and occupancy update; flush wins over same-cycle push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_fire) begin
        r_wptr <= r_wptr + PW'(w_push_num);
      end
      r_rptr  <= r_rptr + PW'(w_pop_num);
      r_count <= r_count + (w_push_fire ? w_push_num : '0) - w_pop_num;
    end
  end

  // Head bundle: oldest entries in lane order, NOP in lanes holding nothing
  always_comb begin
    head_valid = '0;
    head_data  = '0;
    for (int j = 0; j < POP_WIDTH; j++) begin
      head_valid[j] = (r_count > CW'(j));
      head_data[j*LINE_WIDTH +: LINE_WIDTH] =
        head_valid[j] ? r_mem[AW'(r_rptr + PW'(j))] : NOP_VALUE;
    end
  end

  // Status flags come straight from the registered count
  always_comb begin
    count       = r_count;
    full        = (r_count == CW'(DEPTH));
    empty       = (r_count == '0);
    almost_full = (r_count >= CW'(AFULL_THRESH));
  end

`ifndef SYNTHESIS
  // Flag a backend that consumes more packets than the head presents
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      assert (w_pop_req <= w_avail)
        else $warning("pop_count %0d exceeds presented %0d; clipped", w_pop_req, w_avail);
    end
  end
`endif

endmodule
